// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, memory depth, fetch state and fetch entry types
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int IMEM_DEPTH = 512;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// rtl/fetch_fifo2.sv - 2-entry fetch buffer; head is a register so outputs need no mux
module fetch_fifo2
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t tail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail_q <= '0;
            count  <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail_q <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands wherever the popped one left room.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head   <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC register, RUN/FAULT control, redirect and buffer push logic
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     DEPTH    = IMEM_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fault_o
);

    localparam logic [XLEN-1:0] DEPTH_W = XLEN'(DEPTH);

    fetch_state_t state;
    fetch_entry_t head;
    fetch_entry_t din;
    logic [1:0]   count;
    logic         in_range;
    logic         pop;
    logic         push;

    assign in_range = (pc_o < DEPTH_W);
    // A redirect cancels any pop decode offers in the same cycle.
    assign pop      = out_valid && out_ready && !redirect_i;
    assign push     = !redirect_i && (state == RUN) && in_range && ((count != 2'd2) || pop);
    assign din      = '{pc: pc_o, instr: instr_i};

    assign out_valid = (count != 2'd0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

    fetch_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   (din),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o    <= RESET_PC;
            state   <= RUN;
            fault_o <= 1'b0;
        end else if (redirect_i) begin
            pc_o <= redirect_pc_i;
            if (redirect_pc_i < DEPTH_W) begin
                state   <= RUN;
                fault_o <= 1'b0;
            end else begin
                state   <= FAULT;
                fault_o <= 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (!in_range) begin
                        state   <= FAULT;
                        fault_o <= 1'b1;
                    end else if (push) begin
                        pc_o <= pc_o + 32'd1;
                    end
                end
                FAULT: ;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a combinational memory model
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault_o;

    fetch_entry_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch #(.DEPTH(512), .RESET_PC(32'd0)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault_o       (fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h00000113;
            32'd1:   return 32'h00400093;
            32'd2:   return 32'h00100193;
            32'd3:   return 32'hFE20AF23;
            32'd87:  return 32'h00202303;
            default: return {8'hC0, a[23:0]};
        endcase
    endfunction

    assign instr_i = mem_word(pc_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input int first, input int n);
        for (int i = 0; i < n; i++)
            sb.push_back('{pc: 32'(first + i), instr: mem_word(32'(first + i))});
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        out_ready     = 1'b0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        fetch_entry_t e;
        if (!rst && !redirect_i && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got pc %h expected no transfer", out_pc);
            end else begin
                e = sb.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_instr", out_instr, e.instr);
            end
        end
    end

    initial begin
        // Reset values, then a straight stream of words 0..3.
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        out_ready     = 1'b0;
        tick();
        tick();
        check("rst_pc_o", pc_o, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_fault", {31'd0, fault_o}, 32'd0);
        expect_seq(0, 4);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        check("first_valid", {31'd0, out_valid}, 32'd1);
        repeat (4) tick();
        out_ready = 1'b0;
        check("p1_drained", 32'(sb.size()), 32'd0);

        // Back-pressure fills the buffer, then release drains without gaps.
        do_reset();
        repeat (5) tick();
        check("bp_pc_o", pc_o, 32'd2);
        check("bp_out_pc", out_pc, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        expect_seq(0, 6);
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        check("p2_drained", 32'(sb.size()), 32'd0);

        // Redirect with a full buffer and decode ready.
        do_reset();
        repeat (3) tick();
        sb.delete();
        expect_seq(87, 2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd87;
        out_ready     = 1'b1;
        tick();
        redirect_i = 1'b0;
        check("rd_valid_gap", {31'd0, out_valid}, 32'd0);
        check("rd_pc_o", pc_o, 32'd87);
        tick();
        check("rd_out_pc", out_pc, 32'd87);
        check("rd_out_instr", out_instr, 32'h00202303);
        tick();
        tick();
        out_ready = 1'b0;
        check("p3_drained", 32'(sb.size()), 32'd0);

        // Run off the end of memory, then recover with a redirect to 0.
        do_reset();
        expect_seq(0, 512);
        out_ready = 1'b1;
        for (int i = 0; i < 600 && !fault_o; i++) tick();
        check("end_fault", {31'd0, fault_o}, 32'd1);
        check("end_pc_o", pc_o, 32'd512);
        check("end_drained", 32'(sb.size()), 32'd0);
        tick();
        check("end_pc_hold", pc_o, 32'd512);
        check("end_valid", {31'd0, out_valid}, 32'd0);
        expect_seq(0, 2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd0;
        tick();
        redirect_i = 1'b0;
        check("recover_fault", {31'd0, fault_o}, 32'd0);
        check("recover_pc_o", pc_o, 32'd0);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        check("p4_drained", 32'(sb.size()), 32'd0);

        // Out-of-range redirect colliding with a pop.
        do_reset();
        repeat (3) tick();
        sb.delete();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd600;
        out_ready     = 1'b1;
        tick();
        redirect_i = 1'b0;
        check("oor_fault", {31'd0, fault_o}, 32'd1);
        check("oor_valid", {31'd0, out_valid}, 32'd0);
        check("oor_pc_o", pc_o, 32'd600);
        tick();
        tick();
        check("oor_still_empty", {31'd0, out_valid}, 32'd0);
        check("oor_pc_hold", pc_o, 32'd600);
        out_ready = 1'b0;

        // Reset mid-stream beats a simultaneous redirect and a full buffer.
        do_reset();
        repeat (3) tick();
        sb.delete();
        rst           = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd87;
        tick();
        rst        = 1'b0;
        redirect_i = 1'b0;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_pc_o", pc_o, 32'd0);
        check("mid_rst_fault", {31'd0, fault_o}, 32'd0);
        expect_seq(0, 3);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("p6_drained", 32'(sb.size()), 32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
